// File: rtl/ball_renderer_if.sv
// Position handshake between the kinematic integrator (master) and the ball renderer (slave).
interface ball_renderer_if;
   logic       pos_valid;
   logic       pos_ready;
   logic [9:0] pos_x;
   logic [9:0] pos_y;

   modport master (output pos_valid, output pos_x, output pos_y, input pos_ready);
   modport slave  (input pos_valid, input pos_x, input pos_y, output pos_ready);
endinterface

// File: rtl/ball_renderer.sv
// Draws a filled circle into the VGA pixel stream; positions are double-buffered and
// committed on frame_start so the ball never tears mid-frame. Two-stage pixel pipeline.
module ball_renderer #(
   parameter int          H_ACTIVE = 640,
   parameter int          V_ACTIVE = 480,
   parameter int          RADIUS   = 8,
   parameter logic [11:0] BALL_RGB = 12'hF80,
   parameter logic [11:0] BG_RGB   = 12'h000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   ball_renderer_if.slave   pos_if,
   input  logic             i_frame_start,
   input  logic             i_video_on,
   input  logic [9:0]       i_scan_x,
   input  logic [9:0]       i_scan_y,
   input  logic             i_hsync,
   input  logic             i_vsync,
   output logic [11:0]      o_rgb,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_stale,
   output logic [7:0]       o_frame_count
);

   localparam logic [20:0] R_SQ = 21'(RADIUS * RADIUS);

   logic [9:0]         r_px;
   logic [9:0]         r_py;
   logic               r_pend_full;
   logic [9:0]         r_ax;
   logic [9:0]         r_ay;
   logic               r_stale;
   logic [7:0]         r_frame_count;
   logic signed [10:0] r_dx;
   logic signed [10:0] r_dy;
   logic               r_von_d1;
   logic               r_hs_d1;
   logic               r_vs_d1;
   logic [11:0]        r_rgb;
   logic               r_hs_d2;
   logic               r_vs_d2;

   logic               w_xfer;
   logic [9:0]         w_adx;
   logic [9:0]         w_ady;
   logic [20:0]        w_d2;
   logic               w_hit;

   assign pos_if.pos_ready = !r_pend_full;
   assign w_xfer           = pos_if.pos_valid && !r_pend_full;

   // Pending/active position buffers, stale flag and frame counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_px          <= 10'd0;
         r_py          <= 10'd0;
         r_pend_full   <= 1'b0;
         r_ax          <= 10'(H_ACTIVE / 2);
         r_ay          <= 10'(V_ACTIVE / 2);
         r_stale       <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         if (i_frame_start) begin
            r_frame_count <= r_frame_count + 8'd1;
            if (r_pend_full) begin
               r_ax        <= r_px;
               r_ay        <= r_py;
               r_pend_full <= 1'b0;
               r_stale     <= 1'b0;
            end else begin
               // A transfer arriving on the boundary itself waits for the next frame.
               r_stale <= 1'b1;
               if (w_xfer) begin
                  r_px        <= pos_if.pos_x;
                  r_py        <= pos_if.pos_y;
                  r_pend_full <= 1'b1;
               end else begin
                  r_pend_full <= r_pend_full;
               end
            end
         end else if (w_xfer) begin
            r_px        <= pos_if.pos_x;
            r_py        <= pos_if.pos_y;
            r_pend_full <= 1'b1;
         end else begin
            r_pend_full <= r_pend_full;
         end
      end
   end

   // Stage 1: signed offsets from the ball centre, sync/video delayed alongside.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dx     <= 11'sd0;
         r_dy     <= 11'sd0;
         r_von_d1 <= 1'b0;
         r_hs_d1  <= 1'b1;
         r_vs_d1  <= 1'b1;
      end else begin
         r_dx     <= $signed({1'b0, i_scan_x}) - $signed({1'b0, r_ax});
         r_dy     <= $signed({1'b0, i_scan_y}) - $signed({1'b0, r_ay});
         r_von_d1 <= i_video_on;
         r_hs_d1  <= i_hsync;
         r_vs_d1  <= i_vsync;
      end
   end

   // Squaring magnitudes gives the same d2 as squaring the signed offsets.
   assign w_adx = r_dx[10] ? 10'(-r_dx) : r_dx[9:0];
   assign w_ady = r_dy[10] ? 10'(-r_dy) : r_dy[9:0];
   assign w_d2  = (21'(w_adx) * 21'(w_adx)) + (21'(w_ady) * 21'(w_ady));
   assign w_hit = (w_d2 <= R_SQ);

   // Stage 2: colour select and final sync alignment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rgb   <= 12'h000;
         r_hs_d2 <= 1'b1;
         r_vs_d2 <= 1'b1;
      end else begin
         if (!r_von_d1) begin
            r_rgb <= 12'h000;
         end else if (w_hit) begin
            r_rgb <= BALL_RGB;
         end else begin
            r_rgb <= BG_RGB;
         end
         r_hs_d2 <= r_hs_d1;
         r_vs_d2 <= r_vs_d1;
      end
   end

   assign o_rgb         = r_rgb;
   assign o_hsync       = r_hs_d2;
   assign o_vsync       = r_vs_d2;
   assign o_stale       = r_stale;
   assign o_frame_count = r_frame_count;

endmodule

// File: doc/ball_renderer.md
# ball_renderer

Consumer end of the kinematic position interface: accepts ball pixel coordinates produced by the kinematic integrator through a valid/ready handshake and draws the ball into the VGA pixel stream. New positions are buffered and committed only at frame boundaries, so the ball cannot tear mid-frame. Per-pixel circle membership is computed in a 2-stage pipeline, with sync signals delayed to match. The block sits between the kinematic block and the VGA timing generator / DAC output.

## Interface

- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- RADIUS, 8, ball radius in pixels (0..31)
- BALL_RGB, 12'hF80, ball colour, 4:4:4
- BG_RGB, 12'h000, background colour inside the active area

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pos_valid  in  1  producer has a position on pos_x/pos_y
- pos_ready  out  1  block can accept a position this cycle
- pos_x  in  10  ball centre x, unsigned pixels
- pos_y  in  10  ball centre y, unsigned pixels
- frame_start  in  1  1-cycle pulse from timing generator at start of vertical blanking
- video_on  in  1  current scan position is in the active area
- scan_x  in  10  current scan column
- scan_y  in  10  current scan row
- hsync_in  in  1  horizontal sync from timing generator, active-low
- vsync_in  in  1  vertical sync from timing generator, active-low
- rgb  out  12  pixel colour, aligned with hsync_out/vsync_out
- hsync_out  out  1  hsync_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles
- stale  out  1  last frame boundary had no new position
- frame_count  out  8  frame_start counter, wraps

## Operation

- Pending register (px, py, pend_full). `pos_ready = !pend_full`. A transfer occurs when pos_valid && pos_ready; pend_full is set on the next edge.
- Active register (ax, ay) drives rendering. On frame_start with pend_full=1: ax<=px, ay<=py, pend_full<=0, stale<=0.
- On frame_start with pend_full=0: active is unchanged and stale<=1.
- When frame_start and a transfer happen in the same cycle with pend_full=0, the value lands in pending only. It is committed at the next frame_start, and stale<=1 for this boundary.
- When frame_start occurs with pend_full=1 and pos_valid=1, no transfer happens, because ready is low that cycle. pos_ready rises the following cycle.
- frame_count increments on every frame_start and wraps from 255 to 0.
- Stage 1 (registered):
  - dx = {1'b0,scan_x} − {1'b0,ax}, 11-bit signed.
  - dy is computed the same way from scan_y and ay.
  - video_on, hsync_in and vsync_in are registered alongside.
- Stage 2 (registered):
  - d2 = dx·dx + dy·dy, 21-bit unsigned, computed at full width with no truncation.
  - hit = (d2 ≤ RADIUS·RADIUS).
  - rgb = !video_on_d1 ? 12'h000 : (hit ? BALL_RGB : BG_RGB).
- Partially off-screen balls, and centres at any 10-bit value, are clipped naturally by video_on. RADIUS=0 draws only the centre pixel.

## Timing

- Reset values (asynchronous, while rst_n=0):
  - pend_full=0, so pos_ready=1.
  - ax=H_ACTIVE/2 (320), ay=V_ACTIVE/2 (240).
  - stale=0, frame_count=0, rgb=12'h000.
  - hsync_out=1, vsync_out=1, and all pipeline valid/sync stages=1 or 0 to match idle.
- Latency:
  - rgb, hsync_out and vsync_out lag scan_x/scan_y/video_on/sync inputs by exactly 2 clocks.
  - A committed position affects rgb from 2 clocks after the frame_start edge.
- Handshake: at most one transfer per frame. The producer must hold pos_valid and data stable until pos_ready is seen high.
- Reset asserted mid-frame: pipeline and registers return to reset values immediately. Pending data is discarded.
- Throughput: one pixel per clock with no stalls. The render path never depends on pos_valid.

## Test plan

- Reset release, no position, video_on=1 at scan (320,240) → 2 cycles later rgb=12'hF80. At scan (329,240) → rgb=12'h000. pos_ready=1 and stale=0.
- Send (100,50), then frame_start. Scan (108,50) → rgb=BALL_RGB. Scan (109,50) → BG_RGB. Scan (106,56) (d2=72≤64? no) → BG_RGB.
- Send (100,50), then send (200,60) before frame_start → second transfer stalls (pos_ready=0) until the cycle after frame_start. The first frame renders (100,50); after the next frame_start the render is (200,60).
- pos_valid with (10,10) on the same cycle as frame_start, pending empty → stale=1, active unchanged. The next frame_start commits (10,10) and stale=0.
- Position (0,0) with scan (0..8, 0) → ball pixels drawn. video_on=0 at any scan → rgb=12'h000. hsync_out/vsync_out match inputs delayed 2 cycles.
- Assert 256 frame_start pulses → frame_count returns to 0. Assert rst_n=0 mid-frame with pend_full=1 → pos_ready=1 immediately and rgb=0.
